// File: rtl/dbg_monitor_pkg.sv
// Shared constants and helpers for the CPU-lab debug front-end.
// Debounce state encodings, the step counter width and a constant clog2.
package dbg_monitor_pkg;

    localparam int unsigned STEP_CNT_W = 16;

    typedef logic [1:0] deb_state_t;

    localparam deb_state_t DEB_IDLE = 2'd0;
    localparam deb_state_t DEB_FIRE = 2'd1;
    localparam deb_state_t DEB_HELD = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/dbg_debounce.sv
// Step-button synchroniser and debounce FSM; emits one press_pulse per accepted press.
// A press needs DEB_CNT stable high samples, a release DEB_CNT stable low samples.
module dbg_debounce
    import dbg_monitor_pkg::*;
#(
    parameter int unsigned DEB_CNT = 1000000
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse
);

    localparam int unsigned CNT_W = (clog2(DEB_CNT) > 0) ? clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

    logic             btn_meta;
    logic             btn_s;
    deb_state_t       state_q;
    deb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_in;
            btn_s    <= btn_meta;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            state_q <= DEB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DEB_IDLE: begin
                if (!btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DEB_FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEB_FIRE: begin
                state_d = DEB_HELD;
                cnt_d   = '0;
            end
            DEB_HELD: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DEB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DEB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_pulse = (state_q == DEB_FIRE);
    end

endmodule

// File: rtl/dbg_monitor.sv
// Debug front-end top: CPU clock-enable generation, step counter and LED byte mux.
// Define AUTO_SCAN_EN to add scan_sw, the SCAN_DIV parameter and the auto-scan index.
module dbg_monitor
    import dbg_monitor_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned DEB_CNT  = 1000000,
`ifdef AUTO_SCAN_EN
    parameter int unsigned SCAN_DIV = 50000000,
`endif
    localparam int unsigned BYTES   = DATA_W / LED_W,
    localparam int unsigned ENTRIES = NUM_CH * BYTES,
    localparam int unsigned SEL_W   = clog2(ENTRIES + 1)
) (
    input  logic                    clk_100MHz,
    input  logic                    rst,
    input  logic                    step_btn,
    input  logic                    run_sw,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [LED_W-1:0]        flags,
`ifdef AUTO_SCAN_EN
    input  logic                    scan_sw,
`endif
    output logic                    cpu_clk_en,
    output logic [STEP_CNT_W-1:0]   step_cnt,
    output logic [LED_W-1:0]        LED
);

    logic                  press_pulse;
    logic                  cpu_clk_en_q;
    logic [STEP_CNT_W-1:0] step_cnt_q;
    logic [LED_W-1:0]      led_q;
    logic [LED_W-1:0]      led_d;
    logic [SEL_W-1:0]      disp_idx;

    dbg_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .btn_in      (step_btn),
        .press_pulse (press_pulse)
    );

    // Free-run swamps any press; single-step forwards the press one cycle later.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            cpu_clk_en_q <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            cpu_clk_en_q <= run_sw | press_pulse;
            if (cpu_clk_en_q) begin
                step_cnt_q <= step_cnt_q + 1'b1;
            end
        end
    end

`ifdef AUTO_SCAN_EN
    localparam int unsigned DWELL_W = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(SCAN_DIV - 1);

    logic [SEL_W-1:0]   scan_idx_q;
    logic [DWELL_W-1:0] dwell_q;

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            scan_idx_q <= '0;
            dwell_q    <= '0;
        end else if (!scan_sw) begin
            scan_idx_q <= '0;
            dwell_q    <= '0;
        end else if (dwell_q == DWELL_MAX) begin
            dwell_q    <= '0;
            scan_idx_q <= (scan_idx_q == SEL_W'(ENTRIES)) ? '0 : scan_idx_q + 1'b1;
        end else begin
            dwell_q <= dwell_q + 1'b1;
        end
    end

    assign disp_idx = scan_sw ? scan_idx_q : sel;
`else
    assign disp_idx = sel;
`endif

    // Bytes are packed back to back across channels, so entry i is simply byte i of ch_data.
    always_comb begin
        led_d = '0;
        if (disp_idx == SEL_W'(ENTRIES)) begin
            led_d = flags;
        end
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (disp_idx == SEL_W'(i)) begin
                led_d = ch_data[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign cpu_clk_en = cpu_clk_en_q;
    assign step_cnt   = step_cnt_q;
    assign LED        = led_q;

endmodule

// File: tb/tb_dbg_monitor.sv
// Randomised scoreboard bench for dbg_monitor with a sample-counting reference model.
// Also exercises auto-scan when compiled with AUTO_SCAN_EN.
`timescale 1ns/1ps
module tb_dbg_monitor;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LED_W    = 8;
    localparam int unsigned DEB_CNT  = 4;
    localparam int unsigned SCAN_DIV = 3;
    localparam int unsigned BYTES    = DATA_W / LED_W;
    localparam int unsigned ENTRIES  = NUM_CH * BYTES;
    localparam int unsigned SEL_W    = 5;

    typedef struct {
        int          c;
        logic [7:0]  v;
    } led_exp_t;

    logic                     clk_100MHz = 1'b0;
    logic                     rst        = 1'b0;
    logic                     step_btn   = 1'b0;
    logic                     run_sw     = 1'b0;
    logic [SEL_W-1:0]         sel        = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data    = '0;
    logic [LED_W-1:0]         flags      = '0;
`ifdef AUTO_SCAN_EN
    logic                     scan_sw    = 1'b0;
`endif
    logic                     cpu_clk_en;
    logic [15:0]              step_cnt;
    logic [LED_W-1:0]         LED;

    // Reference model and scoreboard state
    int          cyc        = 0;
    bit          in_reset   = 1'b1;
    bit          armed      = 1'b1;
    bit          skip       = 1'b0;
    int          hc         = 0;
    int          lc         = 0;
    int          scan_run   = 0;
    int          fire_at[$];
    int          en_q[$];
    led_exp_t    led_q[$];
    logic [15:0] exp_cnt    = '0;
    int          vectors    = 0;
    int          miscompares = 0;

    dbg_monitor #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .LED_W    (LED_W),
`ifdef AUTO_SCAN_EN
        .SCAN_DIV (SCAN_DIV),
`endif
        .DEB_CNT  (DEB_CNT)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .step_btn   (step_btn),
        .run_sw     (run_sw),
        .sel        (sel),
        .ch_data    (ch_data),
        .flags      (flags),
`ifdef AUTO_SCAN_EN
        .scan_sw    (scan_sw),
`endif
        .cpu_clk_en (cpu_clk_en),
        .step_cnt   (step_cnt),
        .LED        (LED)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [7:0] exp_led(input int unsigned idx);
        logic [DATA_W-1:0] word;
        if (idx < ENTRIES) begin
            word = ch_data[(idx / BYTES) * DATA_W +: DATA_W];
            return 8'(word >> ((idx % BYTES) * LED_W));
        end else if (idx == ENTRIES) begin
            return flags;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        armed    = 1'b1;
        skip     = 1'b0;
        hc       = 0;
        lc       = 0;
        scan_run = 0;
        exp_cnt  = '0;
        fire_at.delete();
        en_q.delete();
        led_q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a press is DEB_CNT consecutive high button samples while armed; the enable
    // appears three edges after the last one. Rearm after DEB_CNT consecutive low samples.
    always @(posedge clk_100MHz) begin
        bit          due;
        int unsigned idx;
        cyc++;
        if (!rst) begin
            in_reset = 1'b1;
            model_reset();
        end else begin
            in_reset = 1'b0;
            if (skip) begin
                skip = 1'b0;
            end else if (armed) begin
                hc = step_btn ? hc + 1 : 0;
                if (hc == DEB_CNT) begin
                    fire_at.push_back(cyc + 3);
                    armed = 1'b0;
                    skip  = 1'b1;
                    lc    = 0;
                end
            end else begin
                lc = step_btn ? 0 : lc + 1;
                if (lc == DEB_CNT) begin
                    armed = 1'b1;
                    hc    = 0;
                end
            end
            due = 1'b0;
            if (fire_at.size() > 0 && fire_at[0] == cyc) begin
                due = 1'b1;
                void'(fire_at.pop_front());
            end
            if (run_sw || due) en_q.push_back(cyc);
            idx = sel;
`ifdef AUTO_SCAN_EN
            if (scan_sw) idx = (scan_run / SCAN_DIV) % (ENTRIES + 1);
            scan_run = scan_sw ? scan_run + 1 : 0;
`endif
            led_q.push_back('{c: cyc, v: exp_led(idx)});
        end
    end

    // Monitor: outputs are valid every cycle, checked mid-cycle against the queues.
    always @(negedge clk_100MHz) begin
        led_exp_t e;
        bit       en_exp;
        if (in_reset) begin
            check("reset_led", 32'(LED), 32'h0);
            check("reset_en", 32'(cpu_clk_en), 32'h0);
            check("reset_step_cnt", 32'(step_cnt), 32'h0);
        end else begin
            if (led_q.size() > 0) begin
                e = led_q.pop_front();
                check("led", 32'(LED), 32'(e.v));
            end else begin
                miscompares++;
                $display("FAIL led_queue at cycle %0d: got empty queue, expected an entry", cyc);
            end
            check("step_cnt", 32'(step_cnt), 32'(exp_cnt));
            while (en_q.size() > 0 && en_q[0] < cyc) void'(en_q.pop_front());
            en_exp = (en_q.size() > 0 && en_q[0] == cyc);
            check("cpu_clk_en", 32'(cpu_clk_en), 32'(en_exp));
            if (en_exp) begin
                void'(en_q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #2;
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        in_reset = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b1;
    endtask

    task automatic rand_display();
        sel     = SEL_W'($urandom_range(0, 31));
        ch_data = {$urandom, $urandom, $urandom, $urandom};
        flags   = 8'($urandom);
    endtask

    initial begin
        int unsigned hi;
        int unsigned lo;
        tick(3);
        rst = 1'b1;
        tick(2);

        // Long hold: exactly one enable
        step_btn = 1'b1;
        tick(20);
        step_btn = 1'b0;
        tick(10);

        // Short glitches: no enable
        repeat (3) begin
            step_btn = 1'b1;
            tick(2);
            step_btn = 1'b0;
            tick(6);
        end

        // Directed display entries
        ch_data[2*DATA_W +: DATA_W] = 32'hA1B2C3D4;
        sel = 5'd9;
        tick(2);
        flags = 8'h81;
        sel   = 5'd16;
        tick(2);
        sel = 5'd17;
        tick(2);

        // Free-run burst
        run_sw = 1'b1;
        tick(10);
        run_sw = 1'b0;
        tick(3);

        // Random button timing, display data and occasional free-run
        for (int b = 0; b < 40; b++) begin
            hi = $urandom_range(1, 9);
            lo = $urandom_range(1, 9);
            run_sw   = ($urandom_range(0, 7) == 0);
            step_btn = 1'b1;
            for (int k = 0; k < int'(hi); k++) begin
                rand_display();
                tick(1);
            end
            step_btn = 1'b0;
            for (int k = 0; k < int'(lo); k++) begin
                rand_display();
                tick(1);
            end
        end
        run_sw = 1'b0;
        tick(6);

        // Reset while the button is held, then keep holding
        step_btn = 1'b1;
        tick(10);
        apply_reset();
        tick(15);
        step_btn = 1'b0;
        tick(8);

        // Step counter wrap: 0xFFFE enables then 3 more leaves 0x0001
        apply_reset();
        run_sw = 1'b1;
        tick(65534 + 3);
        run_sw = 1'b0;
        tick(3);

`ifdef AUTO_SCAN_EN
        rand_display();
        scan_sw = 1'b1;
        tick(60);
        scan_sw = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_display();
            tick(1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
